// File: rtl/axil_m.sv
// axil_m: AXI4-Lite initiator, one outstanding single-beat read or write per local command.
// Latency: valids rise the cycle after cmd accept; best-case write reaches WRESP 2 cycles after accept.
// Backpressure: cmd_ready only in IDLE; AXI stalls are waited out indefinitely; response held until rsp_ready.
module axil_m #(
  parameter int AXI_ADDR_WIDTH = 4,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // local command port
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic                      i_cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [31:0]               i_cmd_wdata,
  input  logic [3:0]                i_cmd_wstrb,
  // local response port
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic                      o_rsp_write,
  output logic [31:0]               o_rsp_rdata,
  output logic [1:0]                o_rsp_resp,
  // status
  output logic                      o_busy,
  output logic [ERR_CNT_WIDTH-1:0]  o_err_count,
  // write address channel
  output logic                      o_awvalid,
  input  logic                      i_awready,
  output logic [AXI_ADDR_WIDTH-1:0] o_awaddr,
  // write data channel
  output logic                      o_wvalid,
  input  logic                      i_wready,
  output logic [31:0]               o_wdata,
  output logic [3:0]                o_wstrb,
  // write response channel
  input  logic                      i_bvalid,
  output logic                      o_bready,
  input  logic [1:0]                i_bresp,
  // read address channel
  output logic                      o_arvalid,
  input  logic                      i_arready,
  output logic [AXI_ADDR_WIDTH-1:0] o_araddr,
  // read data channel
  input  logic                      i_rvalid,
  output logic                      o_rready,
  input  logic [31:0]               i_rdata,
  input  logic [1:0]                i_rresp
);

  localparam int AXI_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WRESP   = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4,
    S_RSP     = 3'd5
  } state_t;

  state_t                      state_q,     state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q,      addr_d;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q,     wdata_d;
  logic [3:0]                  wstrb_q,     wstrb_d;
  logic                        awvalid_q,   awvalid_d;
  logic                        wvalid_q,    wvalid_d;
  logic                        arvalid_q,   arvalid_d;
  logic                        bready_q,    bready_d;
  logic                        rready_q,    rready_d;
  logic                        cmd_ready_q, cmd_ready_d;
  logic                        busy_q,      busy_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic                        rsp_write_q, rsp_write_d;
  logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                  rsp_resp_q,  rsp_resp_d;
  logic [ERR_CNT_WIDTH-1:0]    err_cnt_q,   err_cnt_d;

  // per-cycle helpers
  logic                        aw_done;
  logic                        w_done;
  logic                        capture;
  logic [1:0]                  cap_resp;

  // Transaction FSM: next state, latched command, captured response and the
  // registered handshake outputs (derived from the next state so they are flops).
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    err_cnt_d   = err_cnt_q;
    aw_done     = 1'b0;
    w_done      = 1'b0;
    capture     = 1'b0;
    cap_resp    = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          addr_d  = i_cmd_addr;
          wdata_d = i_cmd_wdata;
          wstrb_d = i_cmd_wstrb;
          if (i_cmd_write) begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end

      S_WR: begin
        // AW and W retire independently; a channel already done counts as done.
        aw_done = !awvalid_q || i_awready;
        w_done  = !wvalid_q  || i_wready;
        if (awvalid_q && i_awready) awvalid_d = 1'b0;
        if (wvalid_q  && i_wready)  wvalid_d  = 1'b0;
        if (aw_done && w_done)      state_d   = S_WRESP;
      end

      S_WRESP: begin
        if (i_bvalid) begin
          rsp_resp_d  = i_bresp;
          rsp_rdata_d = '0;
          rsp_write_d = 1'b1;
          capture     = 1'b1;
          cap_resp    = i_bresp;
          state_d     = S_RSP;
        end
      end

      S_RD_ADDR: begin
        if (i_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        if (i_rvalid) begin
          rsp_resp_d  = i_rresp;
          rsp_rdata_d = i_rdata;
          rsp_write_d = 1'b0;
          capture     = 1'b1;
          cap_resp    = i_rresp;
          state_d     = S_RSP;
        end
      end

      S_RSP: begin
        if (i_rsp_ready) state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
      end
    endcase

    // Non-OKAY responses are counted once, at capture; the counter sticks at all-ones.
    if (capture && (cap_resp != 2'b00) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end

    bready_d    = (state_d == S_WRESP);
    rready_d    = (state_d == S_RD_DATA);
    rsp_valid_d = (state_d == S_RSP);
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers; reset drops every valid immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // A single latched address serves both AW and AR; only one is ever valid.
  assign o_cmd_ready = cmd_ready_q;
  assign o_busy      = busy_q;
  assign o_err_count = err_cnt_q;
  assign o_awvalid   = awvalid_q;
  assign o_awaddr    = addr_q;
  assign o_wvalid    = wvalid_q;
  assign o_wdata     = wdata_q;
  assign o_wstrb     = wstrb_q;
  assign o_bready    = bready_q;
  assign o_arvalid   = arvalid_q;
  assign o_araddr    = addr_q;
  assign o_rready    = rready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_write = rsp_write_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_resp  = rsp_resp_q;

`ifndef SYNTHESIS
  // Channel valids hold, with stable payload, until their handshake.
  a_aw_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (o_awvalid && !i_awready) |=> (o_awvalid && $stable(o_awaddr)));
  a_w_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (o_wvalid && !i_wready) |=> (o_wvalid && $stable(o_wdata) && $stable(o_wstrb)));
  a_ar_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (o_arvalid && !i_arready) |=> (o_arvalid && $stable(o_araddr)));
  // Write and read activity never overlap.
  a_no_mix: assert property (@(posedge clk) disable iff (!rst_n)
    !((o_awvalid || o_wvalid || o_bready) && (o_arvalid || o_rready)));
`endif

endmodule
